mmio_fifo_ctrl: RTL and testbench
=================================

Name: mmio_fifo_ctrl

Overview:
- MMIO-side controller for the AFU's 64-bit FIFO. Decodes CCI-P MMIO writes and reads aimed at the FIFO window and turns them into registered push/pop strobes for the FIFO.
- Keeps its own occupancy count, sticky overflow/underflow flags and a flush sequencer.
- Returns pop data and status as tid-tagged read responses, which the AFU top muxes onto tx.c2.

Parameters:
- DEPTH, 8: FIFO entry count; power of two, 2..1024.
- CW, $clog2(DEPTH)+1: count width (derived, localparam).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mmio_wr_valid  in  1  MMIO write strobe (rx.c0.mmioWrValid)
- mmio_rd_valid  in  1  MMIO read strobe (rx.c0.mmioRdValid)
- mmio_addr  in  16  MMIO dword address
- mmio_tid  in  9  read transaction id
- mmio_wdata  in  64  write data
- fifo_push  out  1  push strobe to FIFO
- fifo_wdata  out  64  push data, valid with fifo_push
- fifo_pop  out  1  pop strobe to FIFO
- fifo_rdata  in  64  FIFO head data, valid the cycle after fifo_pop
- rd_rsp_valid  out  1  read response strobe
- rd_rsp_tid  out  9  tid echoed from request
- rd_rsp_data  out  64  read response data
- count  out  CW  committed occupancy
- level_irq  out  1  watermark indication (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n. While rst_n=0 all outputs, count, flags, pipeline and FSM are 0/IDLE.
- Address map:
  - 0x0020 write = push; 0x0020 read = pop.
  - 0x0022 read = status: [CW-1:0] count, [16] empty, [17] full, [18] overflow, [19] underflow, [20] flush_busy; other bits 0.
  - 0x0024 write = control: bit0 clears overflow/underflow, bit1 starts flush. 0x0024 read returns 0.
  - Any other address: write ignored, read produces no response; the top handles the DFH/ID registers.
- Push (write 0x20, cycle N):
  - If count<DEPTH and FSM=IDLE: fifo_push=1 and fifo_wdata=mmio_wdata in cycle N+1; count increments at the N/N+1 edge.
  - Otherwise: no push and overflow is set. A write dropped during FLUSH also sets overflow.
- Pop (read 0x20, cycle N):
  - If count>0 and IDLE: fifo_pop=1 in N+1; count decrements at the N/N+1 edge. fifo_rdata is sampled in N+2. rd_rsp_valid=1 in N+3 with that data and the request's tid.
  - If count==0 or FSM=FLUSH: no pop, underflow set only when count==0, response carries 0.
- Read latency: every owned-address read responds exactly 3 cycles after the request.
  - Reads may arrive every cycle; the 3-stage tid/addr/kind pipeline gives one response per cycle in order.
  - Status is snapshotted in cycle N, using the committed count before that cycle's update.
- Simultaneous write 0x20 and read 0x20 in the same cycle: decisions use the pre-cycle count.
  - Both are honoured if legal, and count is unchanged.
  - Push at full with pop legal: the push is refused (overflow) and the pop proceeds.
- Flag-clear in the same cycle as a new overflow/underflow event: the set wins.
- Flush FSM:
  - IDLE -> FLUSH on a write of 0x24 with bit1=1 while count>0. With count==0 the write is a no-op.
  - In FLUSH: fifo_pop=1 each cycle, count decrements, no responses are generated for the flushed data.
  - FLUSH -> IDLE on the cycle count reaches 0.
- count saturates at 0 and DEPTH and never wraps.
- rd_rsp_valid is a single-cycle pulse per response.
- Asserting rst_n low mid-flush or mid-pipeline aborts immediately. Pending responses are discarded and not replayed.

Optional Feature:
- Macro: MMIO_FIFO_CTRL_WATERMARK_EN.
- Defined:
  - Adds a watermark register (CW bits, reset DEPTH) writable at 0x0026 and readable at 0x0026 with 3-cycle latency.
  - level_irq is registered and =1 when count>=watermark, updated one cycle after count changes.
- Undefined: level_irq is tied 0. 0x0026 writes are ignored and reads produce no response.

Test Plan (DEPTH=8):
- Reset, then 3 writes of 0x11,0x22,0x33 to 0x20, then 3 reads of 0x20 with tids 5,6,7 -> responses 0x11/5, 0x22/6, 0x33/7, each 3 cycles after its request; count 3 then 0.
- 9 writes to 0x20 -> 8 fifo_push pulses; status read returns count=8, full=1, overflow=1. Then write 0x24=0x1 -> overflow=0.
- Read 0x20 while empty -> no fifo_pop, response data 0, underflow=1, count stays 0.
- Fill to 5, write 0x24=0x2 -> 5 consecutive fifo_pop cycles with no responses; flush_busy=1 during the flush; a write to 0x20 during the flush sets overflow; count ends at 0, FSM returns to IDLE.
- At count=8, write and read 0x20 in the same cycle -> pop proceeds, push refused, overflow=1, count=7.
- With MMIO_FIFO_CTRL_WATERMARK_EN, write 0x26=4, push 4 entries -> level_irq rises the cycle after count=4 and falls after one pop; assert rst_n low mid-flush -> all outputs 0 and count 0.

Source files
------------

// File: rtl/mmio_fifo_ctrl_if.sv
// rtl/mmio_fifo_ctrl_if.sv - MMIO request, FIFO strobe and read-response signals of mmio_fifo_ctrl
interface mmio_fifo_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mmio_wr_valid;
  logic          mmio_rd_valid;
  logic [15:0]   mmio_addr;
  logic [8:0]    mmio_tid;
  logic [63:0]   mmio_wdata;
  logic          fifo_push;
  logic [63:0]   fifo_wdata;
  logic          fifo_pop;
  logic [63:0]   fifo_rdata;
  logic          rd_rsp_valid;
  logic [8:0]    rd_rsp_tid;
  logic [63:0]   rd_rsp_data;
  logic [CW-1:0] count;
  logic          level_irq;

  modport master (
    output mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata, fifo_rdata,
    input  fifo_push, fifo_wdata, fifo_pop, rd_rsp_valid, rd_rsp_tid, rd_rsp_data, count, level_irq
  );

  modport slave (
    input  mmio_wr_valid, mmio_rd_valid, mmio_addr, mmio_tid, mmio_wdata, fifo_rdata,
    output fifo_push, fifo_wdata, fifo_pop, rd_rsp_valid, rd_rsp_tid, rd_rsp_data, count, level_irq
  );
endinterface

// File: rtl/mmio_fifo_ctrl.sv
// rtl/mmio_fifo_ctrl.sv - MMIO decode, occupancy/flag tracking and flush sequencing for the AFU FIFO
// Optional watermark register and level_irq: define MMIO_FIFO_CTRL_WATERMARK_EN.
module mmio_fifo_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  mmio_fifo_ctrl_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [15:0]   ADDR_DATA = 16'h0020;
  localparam logic [15:0]   ADDR_STAT = 16'h0022;
  localparam logic [15:0]   ADDR_CTRL = 16'h0024;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          push_q, push_d, pop_q, pop_d;
  logic [63:0]   wdata_q, wdata_d;
  logic          s1_vld_q, s1_vld_d, s1_pop_q, s1_pop_d;
  logic [8:0]    s1_tid_q, s1_tid_d;
  logic [63:0]   s1_data_q, s1_data_d;
  logic          s2_vld_q, s2_vld_d, s2_pop_q, s2_pop_d;
  logic [8:0]    s2_tid_q, s2_tid_d;
  logic [63:0]   s2_data_q, s2_data_d;
  logic          rsp_vld_q, rsp_vld_d;
  logic [8:0]    rsp_tid_q, rsp_tid_d;
  logic [63:0]   rsp_data_q, rsp_data_d;

  logic          wr_push, rd_pop, rd_stat, rd_ctrl, wr_ctrl;
  logic          idle, push_ok, pop_ok;
  logic [63:0]   status;
  logic          wm_rd;
  logic [63:0]   wm_rdata;

`ifdef MMIO_FIFO_CTRL_WATERMARK_EN
  localparam logic [15:0] ADDR_WM = 16'h0026;
  logic [CW-1:0] wm_q, wm_d;
  logic          lvl_q, lvl_d;
  logic          wm_wr;

  assign wm_rd    = bus.mmio_rd_valid && (bus.mmio_addr == ADDR_WM);
  assign wm_wr    = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_WM);
  assign wm_rdata = 64'(wm_q);

  // level follows the committed count, so it lags a count change by one cycle
  always_comb begin
    wm_d  = wm_wr ? bus.mmio_wdata[CW-1:0] : wm_q;
    lvl_d = (count_q >= wm_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wm_q  <= FULL_CNT;
      lvl_q <= 1'b0;
    end else begin
      wm_q  <= wm_d;
      lvl_q <= lvl_d;
    end
  end

  assign bus.level_irq = lvl_q;
`else
  assign wm_rd         = 1'b0;
  assign wm_rdata      = '0;
  assign bus.level_irq = 1'b0;
`endif

  always_comb begin
    wr_push = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_DATA);
    wr_ctrl = bus.mmio_wr_valid && (bus.mmio_addr == ADDR_CTRL);
    rd_pop  = bus.mmio_rd_valid && (bus.mmio_addr == ADDR_DATA);
    rd_stat = bus.mmio_rd_valid && (bus.mmio_addr == ADDR_STAT);
    rd_ctrl = bus.mmio_rd_valid && (bus.mmio_addr == ADDR_CTRL);
    idle    = (state_q == IDLE);
    // all decisions use the committed count from before this cycle
    push_ok = wr_push && idle && (count_q != FULL_CNT);
    pop_ok  = rd_pop && idle && (count_q != '0);

    status         = '0;
    status[CW-1:0] = count_q;
    status[16]     = (count_q == '0);
    status[17]     = (count_q == FULL_CNT);
    status[18]     = ovf_q;
    status[19]     = udf_q;
    status[20]     = !idle;

    state_d = state_q;
    count_d = count_q;
    push_d  = push_ok;
    pop_d   = pop_ok;
    wdata_d = push_ok ? bus.mmio_wdata : wdata_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + ONE;
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - ONE;
    end

    if (!idle) begin
      if (count_q != '0) begin
        pop_d   = 1'b1;
        count_d = count_q - ONE;
      end
      if (count_q <= ONE) state_d = IDLE;
    end else if (wr_ctrl && bus.mmio_wdata[1] && (count_q != '0)) begin
      state_d = FLUSH;
    end

    // a new event in the same cycle as a clear leaves the flag set
    ovf_d = (ovf_q && !(wr_ctrl && bus.mmio_wdata[0])) || (wr_push && !push_ok);
    udf_d = (udf_q && !(wr_ctrl && bus.mmio_wdata[0])) || (rd_pop && (count_q == '0));

    s1_vld_d  = rd_pop || rd_stat || rd_ctrl || wm_rd;
    s1_tid_d  = bus.mmio_tid;
    s1_pop_d  = pop_ok;
    s1_data_d = rd_stat ? status : (wm_rd ? wm_rdata : '0);

    s2_vld_d  = s1_vld_q;
    s2_tid_d  = s1_tid_q;
    s2_pop_d  = s1_pop_q;
    s2_data_d = s1_data_q;

    rsp_vld_d  = s2_vld_q;
    rsp_tid_d  = s2_tid_q;
    rsp_data_d = s2_pop_q ? bus.fifo_rdata : s2_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      wdata_q    <= '0;
      s1_vld_q   <= 1'b0;
      s1_pop_q   <= 1'b0;
      s1_tid_q   <= '0;
      s1_data_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_pop_q   <= 1'b0;
      s2_tid_q   <= '0;
      s2_data_q  <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_tid_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      push_q     <= push_d;
      pop_q      <= pop_d;
      wdata_q    <= wdata_d;
      s1_vld_q   <= s1_vld_d;
      s1_pop_q   <= s1_pop_d;
      s1_tid_q   <= s1_tid_d;
      s1_data_q  <= s1_data_d;
      s2_vld_q   <= s2_vld_d;
      s2_pop_q   <= s2_pop_d;
      s2_tid_q   <= s2_tid_d;
      s2_data_q  <= s2_data_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_tid_q  <= rsp_tid_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.fifo_push    = push_q;
  assign bus.fifo_wdata   = wdata_q;
  assign bus.fifo_pop     = pop_q;
  assign bus.rd_rsp_valid = rsp_vld_q;
  assign bus.rd_rsp_tid   = rsp_tid_q;
  assign bus.rd_rsp_data  = rsp_data_q;
  assign bus.count        = count_q;
endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb/tb_mmio_fifo_ctrl.sv - scoreboard bench for mmio_fifo_ctrl with an emulated 64-bit FIFO
module tb_mmio_fifo_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mmio_fifo_ctrl_if #(.DEPTH(DEPTH)) bus ();
  mmio_fifo_ctrl #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } rsp_t;

  rsp_t        sb[$];
  logic [63:0] fq[$];
  logic [63:0] mq[$];
  int          mcount, mwm;
  bit          movf, mudf, mflush;
  int          cyc = 0;
  int          n_cmp = 0, n_bad = 0;
  int          n_push = 0, n_pop = 0;
  bit          pop_seen = 0;
  rsp_t        mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO emulation: head data appears the cycle after a pop strobe
  always @(negedge clk) begin
    pop_seen = 1'b0;
    if (rst_n) begin
      if (bus.fifo_push) begin
        fq.push_back(bus.fifo_wdata);
        n_push++;
      end
      if (bus.fifo_pop) begin
        pop_seen = 1'b1;
        n_pop++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (pop_seen) begin
      if (fq.size() > 0) bus.fifo_rdata = fq.pop_front();
      else bus.fifo_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        check("rsp_valid", 64'(bus.rd_rsp_valid), 64'd1);
        if (bus.rd_rsp_valid) begin
          check("rsp_tid", 64'(bus.rd_rsp_tid), 64'(mon_e.tid));
          check("rsp_data", bus.rd_rsp_data, mon_e.data);
        end
      end else if (bus.rd_rsp_valid) begin
        check("rsp_unexpected", 64'(bus.rd_rsp_valid), 64'd0);
      end
    end
  end

  task automatic model_reset();
    sb.delete();
    fq.delete();
    mq.delete();
    mcount = 0;
    movf   = 0;
    mudf   = 0;
    mflush = 0;
    mwm    = DEPTH;
  endtask

  task automatic step(input bit wr, input bit rd, input logic [15:0] addr,
                      input logic [63:0] wd, input logic [8:0] tid);
    logic [63:0] st;
    rsp_t        r;
    bit          push_ok, pop_ok, owned, pf;
    int          pc;
    @(negedge clk);
    check("count", 64'(bus.count), 64'(mcount));
    bus.mmio_wr_valid = wr;
    bus.mmio_rd_valid = rd;
    bus.mmio_addr     = addr;
    bus.mmio_wdata    = wd;
    bus.mmio_tid      = tid;

    pc = mcount;
    pf = mflush;
    st = '0;
    st[3:0] = 4'(mcount);
    st[16]  = (mcount == 0);
    st[17]  = (mcount == DEPTH);
    st[18]  = movf;
    st[19]  = mudf;
    st[20]  = mflush;
    push_ok = wr && addr == 16'h20 && !pf && pc < DEPTH;
    pop_ok  = rd && addr == 16'h20 && !pf && pc > 0;

    if (rd) begin
      owned  = 1;
      r.tid  = tid;
      r.due  = cyc + 3;
      r.data = '0;
      case (addr)
        16'h20: if (pop_ok) r.data = mq[0];
        16'h22: r.data = st;
        16'h24: r.data = '0;
`ifdef MMIO_FIFO_CTRL_WATERMARK_EN
        16'h26: r.data = 64'(mwm);
`endif
        default: owned = 0;
      endcase
      if (owned) sb.push_back(r);
    end

    if (pf) begin
      if (mcount > 0) begin
        mcount--;
        void'(mq.pop_front());
      end
      if (mcount == 0) mflush = 0;
    end
    if (pop_ok) begin
      void'(mq.pop_front());
      mcount--;
    end
    if (push_ok) begin
      mq.push_back(wd);
      mcount++;
    end
    if (wr && addr == 16'h24 && wd[0]) begin
      movf = 0;
      mudf = 0;
    end
    if (wr && addr == 16'h20 && !push_ok) movf = 1;
    if (rd && addr == 16'h20 && pc == 0) mudf = 1;
    if (wr && addr == 16'h24 && wd[1] && !pf && pc > 0) mflush = 1;
`ifdef MMIO_FIFO_CTRL_WATERMARK_EN
    if (wr && addr == 16'h26) mwm = int'(wd[3:0]);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 16'h0, 64'h0, 9'h0);
  endtask

  task automatic push_n(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) step(1, 0, 16'h20, base + 64'(i), 9'h0);
  endtask

  task automatic pop_n(input int n, input logic [8:0] tid0);
    for (int i = 0; i < n; i++) step(0, 1, 16'h20, 64'h0, tid0 + 9'(i));
  endtask

  int p0;

  initial begin
    rst_n = 1'b0;
    bus.mmio_wr_valid = 0;
    bus.mmio_rd_valid = 0;
    bus.mmio_addr     = '0;
    bus.mmio_wdata    = '0;
    bus.mmio_tid      = '0;
    bus.fifo_rdata    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_push", 64'(bus.fifo_push), 64'd0);
    check("rst_pop", 64'(bus.fifo_pop), 64'd0);
    check("rst_rsp_valid", 64'(bus.rd_rsp_valid), 64'd0);
    check("rst_level_irq", 64'(bus.level_irq), 64'd0);
    rst_n = 1'b1;

    // basic push then in-order tagged pops
    step(1, 0, 16'h20, 64'h11, 9'd0);
    step(1, 0, 16'h20, 64'h22, 9'd0);
    step(1, 0, 16'h20, 64'h33, 9'd0);
    idle(1);
    check("count_after_fill", 64'(bus.count), 64'd3);
    pop_n(3, 9'd5);
    idle(4);
    check("count_after_drain", 64'(bus.count), 64'd0);

    // overflow at full, then clear
    p0 = n_push;
    push_n(9, 64'h100);
    idle(2);
    check("push_pulses", 64'(n_push - p0), 64'd8);
    step(0, 1, 16'h22, 64'h0, 9'd1);
    step(1, 0, 16'h24, 64'h1, 9'd0);
    step(0, 1, 16'h22, 64'h0, 9'd2);
    pop_n(8, 9'd10);
    idle(4);

    // underflow on empty
    p0 = n_pop;
    step(0, 1, 16'h20, 64'h0, 9'd3);
    idle(4);
    check("pop_on_empty", 64'(n_pop - p0), 64'd0);
    step(0, 1, 16'h22, 64'h0, 9'd4);
    step(0, 1, 16'h24, 64'h0, 9'd40);
    step(1, 0, 16'h24, 64'h1, 9'd0);
    idle(3);

    // flush of 5 entries with a rejected push during the flush
    push_n(5, 64'h200);
    p0 = n_pop;
    step(1, 0, 16'h24, 64'h2, 9'd0);
    step(1, 0, 16'h20, 64'hBAD, 9'd0);
    step(0, 1, 16'h22, 64'h0, 9'd11);
    idle(8);
    check("flush_pops", 64'(n_pop - p0), 64'd5);
    check("flush_count", 64'(bus.count), 64'd0);
    step(0, 1, 16'h22, 64'h0, 9'd12);
    step(1, 0, 16'h24, 64'h1, 9'd0);
    idle(3);

    // simultaneous push and pop at full
    push_n(8, 64'h300);
    step(1, 1, 16'h20, 64'h99, 9'd9);
    idle(4);
    check("simul_count", 64'(bus.count), 64'd7);
    step(0, 1, 16'h22, 64'h0, 9'd13);
    pop_n(7, 9'd50);
    step(1, 0, 16'h24, 64'h1, 9'd0);
    idle(4);

`ifdef MMIO_FIFO_CTRL_WATERMARK_EN
    step(1, 0, 16'h26, 64'h4, 9'd0);
    push_n(4, 64'h400);
    idle(1);
    check("lvl_at_cnt4", 64'(bus.level_irq), 64'd0);
    idle(1);
    check("lvl_rise", 64'(bus.level_irq), 64'd1);
    step(0, 1, 16'h20, 64'h0, 9'd20);
    idle(1);
    check("lvl_hold", 64'(bus.level_irq), 64'd1);
    idle(1);
    check("lvl_fall", 64'(bus.level_irq), 64'd0);
    step(0, 1, 16'h26, 64'h0, 9'd21);
    pop_n(3, 9'd22);
    idle(4);
`else
    step(1, 0, 16'h26, 64'h4, 9'd0);
    step(0, 1, 16'h26, 64'h0, 9'd21);
    idle(4);
    check("lvl_tied", 64'(bus.level_irq), 64'd0);
`endif

    // reset mid-flush with a read still in flight
    push_n(5, 64'h500);
    step(1, 0, 16'h24, 64'h2, 9'd0);
    step(0, 1, 16'h22, 64'h0, 9'd30);
    idle(1);
    @(negedge clk);
    bus.mmio_wr_valid = 0;
    bus.mmio_rd_valid = 0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_pop", 64'(bus.fifo_pop), 64'd0);
    check("mid_rst_push", 64'(bus.fifo_push), 64'd0);
    check("mid_rst_rsp", 64'(bus.rd_rsp_valid), 64'd0);
    check("mid_rst_lvl", 64'(bus.level_irq), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    step(0, 1, 16'h22, 64'h0, 9'd31);
    step(1, 0, 16'h20, 64'h77, 9'd0);
    step(0, 1, 16'h20, 64'h0, 9'd32);
    idle(5);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
